// File: rtl/fuzzy_sweep_sequencer.sv
`default_nettype none
// ============================================================================
// Module : fuzzy_sweep_sequencer
// Sweeps the Fuzzy_1 inputs over a clamped 2-D grid, waits a settle time per
// point and streams (x, y, result) records over a valid/ready handshake.
// Rev    : 1.0  initial release
// ============================================================================
module fuzzy_sweep_sequencer #(
    parameter int STEP   = 1,
    parameter int LAST   = 254,
    parameter int MIN_IN = 1,
    parameter int MAX_IN = 254,
    parameter int SETTLE = 6
) (
    input  logic       clk_0,
    input  logic       Srst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] saida_defuzzy,
    input  logic [5:0] FOU_ATIVO,
    output logic [7:0] Entrada_01,
    output logic [7:0] Entrada_02,
    output logic       EN_REGRAS,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_x,
    output logic [7:0] out_y,
    output logic [7:0] out_data,
    output logic [5:0] out_fou,
    output logic       out_last,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = $clog2(SETTLE);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_EMIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [9:0]       c_step     = 10'(STEP);
    localparam logic [9:0]       c_last     = 10'(LAST);
    localparam logic [8:0]       c_min9     = 9'(MIN_IN);
    localparam logic [8:0]       c_max9     = 9'(MAX_IN);
    localparam logic [7:0]       c_min8     = 8'(MIN_IN);
    localparam logic [7:0]       c_max8     = 8'(MAX_IN);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [8:0]       r_i;
    logic [8:0]       r_j;
    logic [CNT_W-1:0] r_cnt;

    logic [9:0] w_i_next;
    logic [9:0] w_j_next;
    logic       w_i_end;
    logic       w_j_end;

    function automatic logic [7:0] drive(input logic [8:0] k);
        logic [7:0] v;
        if (k < c_min9)      v = c_min8;
        else if (k > c_max9) v = c_max8;
        else                 v = k[7:0];
        return v;
    endfunction

    // One extra bit keeps i+STEP from wrapping when LAST approaches 511.
    assign w_i_next = {1'b0, r_i} + c_step;
    assign w_j_next = {1'b0, r_j} + c_step;
    assign w_i_end  = (w_i_next > c_last);
    assign w_j_end  = (w_j_next > c_last);

    assign busy      = (r_state == S_SETTLE) || (r_state == S_EMIT);
    assign done      = (r_state == S_DONE);
    assign EN_REGRAS = (r_state == S_SETTLE);

    always_ff @(posedge clk_0) begin
        if (Srst) begin
            r_state    <= S_IDLE;
            r_i        <= '0;
            r_j        <= '0;
            r_cnt      <= '0;
            Entrada_01 <= c_min8;
            Entrada_02 <= c_min8;
            out_valid  <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            out_data   <= '0;
            out_fou    <= '0;
            out_last   <= 1'b0;
        end else if (abort) begin
            // A pending record is simply dropped.
            r_state   <= S_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_i        <= '0;
                        r_j        <= '0;
                        r_cnt      <= '0;
                        Entrada_01 <= drive(9'd0);
                        Entrada_02 <= drive(9'd0);
                        r_state    <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    r_cnt <= r_cnt + c_cnt_one;
                    if (r_cnt == c_cnt_last) begin
                        out_data  <= saida_defuzzy;
                        out_fou   <= FOU_ATIVO;
                        out_x     <= drive(r_i);
                        out_y     <= drive(r_j);
                        out_last  <= w_i_end && w_j_end;
                        out_valid <= 1'b1;
                        r_state   <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= S_SETTLE;
                            if (!w_j_end) begin
                                r_j        <= w_j_next[8:0];
                                Entrada_02 <= drive(w_j_next[8:0]);
                            end else begin
                                r_j        <= '0;
                                r_i        <= w_i_next[8:0];
                                Entrada_01 <= drive(w_i_next[8:0]);
                                Entrada_02 <= drive(9'd0);
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fuzzy_sweep_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_fuzzy_sweep_sequencer
// Directed bench for fuzzy_sweep_sequencer on a 3x3 grid (STEP=128, LAST=256).
// Rev    : 1.0  initial release
// ============================================================================
module tb_fuzzy_sweep_sequencer;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       last;
    } vec_t;

    logic       clk_0 = 1'b0;
    logic       Srst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] saida_defuzzy = 8'd0;
    logic [5:0] FOU_ATIVO = 6'd0;
    logic [7:0] Entrada_01, Entrada_02;
    logic       EN_REGRAS, out_valid, out_last, busy, done;
    logic [7:0] out_x, out_y, out_data;
    logic [5:0] out_fou;

    logic [15:0] tick = 16'd0;
    int          n_cmp = 0;
    int          n_fail = 0;
    vec_t        vecs[9];

    fuzzy_sweep_sequencer #(
        .STEP(128), .LAST(256), .MIN_IN(1), .MAX_IN(254), .SETTLE(6)
    ) dut (
        .clk_0(clk_0), .Srst(Srst), .start(start), .abort(abort),
        .saida_defuzzy(saida_defuzzy), .FOU_ATIVO(FOU_ATIVO),
        .Entrada_01(Entrada_01), .Entrada_02(Entrada_02), .EN_REGRAS(EN_REGRAS),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_data(out_data), .out_fou(out_fou),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk_0 = ~clk_0;

    // Controller stand-in: a free-running pattern makes the sample instant visible.
    always @(negedge clk_0) begin
        tick          = tick + 16'd1;
        saida_defuzzy = tick[7:0];
        FOU_ATIVO     = ~tick[5:0];
    end

    task automatic step();
        @(posedge clk_0);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic get_record(input int k, input int exp_n);
        int n = 0;
        while (!out_valid && n < 64) begin
            step();
            n++;
        end
        chk($sformatf("wait[%0d]", k), 64'(n), 64'(exp_n));
        chk($sformatf("x[%0d]", k), out_x, vecs[k].x);
        chk($sformatf("y[%0d]", k), out_y, vecs[k].y);
        chk($sformatf("last[%0d]", k), out_last, vecs[k].last);
        chk($sformatf("data[%0d]", k), out_data, saida_defuzzy);
        chk($sformatf("fou[%0d]", k), out_fou, FOU_ATIVO);
        chk($sformatf("inputs[%0d]", k), {Entrada_01, Entrada_02}, {vecs[k].x, vecs[k].y});
        chk($sformatf("busy[%0d]", k), busy, 1'b1);
    endtask

    task automatic chk_done(input string tag);
        chk({tag, "_done"}, {done, busy, EN_REGRAS, out_valid}, 4'b1000);
        chk({tag, "_inputs"}, {Entrada_01, Entrada_02}, {8'd254, 8'd254});
    endtask

    initial begin
        logic [7:0] d0;
        logic [5:0] f0;
        int         seen;

        vecs[0] = '{8'd1,   8'd1,   1'b0};
        vecs[1] = '{8'd1,   8'd128, 1'b0};
        vecs[2] = '{8'd1,   8'd254, 1'b0};
        vecs[3] = '{8'd128, 8'd1,   1'b0};
        vecs[4] = '{8'd128, 8'd128, 1'b0};
        vecs[5] = '{8'd128, 8'd254, 1'b0};
        vecs[6] = '{8'd254, 8'd1,   1'b0};
        vecs[7] = '{8'd254, 8'd128, 1'b0};
        vecs[8] = '{8'd254, 8'd254, 1'b1};

        // Reset then idle.
        repeat (3) step();
        Srst = 1'b0;
        repeat (20) step();
        chk("rst_inputs", {Entrada_01, Entrada_02}, {8'd1, 8'd1});
        chk("rst_flags", {out_valid, busy, done, EN_REGRAS, out_last}, 5'b0);
        chk("rst_outs", {out_x, out_y, out_data, out_fou}, 30'd0);

        // Full sweep with the consumer always ready.
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("settle_en", {busy, EN_REGRAS, out_valid}, 3'b110);
        for (int k = 0; k < 9; k++) begin
            get_record(k, 6);
            step();
        end
        chk_done("sweep");
        repeat (3) step();
        chk_done("sweep_hold");

        // Backpressure, restarting from DONE.
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        get_record(0, 6);
        d0 = out_data;
        f0 = out_fou;
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("bp_hold[%0d]", c),
                {out_valid, out_x, out_y, out_data, out_fou, Entrada_01, Entrada_02},
                {1'b1, 8'd1, 8'd1, d0, f0, 8'd1, 8'd1});
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release", {out_valid, Entrada_01, Entrada_02}, {1'b0, 8'd1, 8'd128});
        get_record(1, 6);

        // Abort while the 4th record is pending.
        out_ready = 1'b1;
        step();
        get_record(2, 6);
        step();
        get_record(3, 6);
        abort = 1'b1;
        out_ready = 1'b0;
        step();
        abort = 1'b0;
        chk("abort_idle", {out_valid, busy, done, EN_REGRAS}, 4'b0);
        seen = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            step();
            if (out_valid || busy) seen++;
        end
        chk("abort_quiet", 64'(seen), 64'd0);

        // Restart after abort, then reset together with start mid-SETTLE.
        start = 1'b1;
        step();
        start = 1'b0;
        get_record(0, 6);
        repeat (3) step();
        chk("pre_rst_settle", {busy, EN_REGRAS, Entrada_02}, {1'b1, 1'b1, 8'd128});
        Srst = 1'b1;
        start = 1'b1;
        step();
        Srst = 1'b0;
        start = 1'b0;
        chk("rst2_inputs", {Entrada_01, Entrada_02}, {8'd1, 8'd1});
        chk("rst2_flags", {out_valid, busy, done, EN_REGRAS, out_last}, 5'b0);
        chk("rst2_outs", {out_x, out_y, out_data, out_fou}, 30'd0);
        step();
        chk("rst2_stays_idle", busy, 1'b0);

        // start pulsed while busy must not disturb the sweep.
        start = 1'b1;
        step();
        start = 1'b0;
        get_record(0, 6);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        get_record(1, 4);
        for (int k = 2; k < 9; k++) begin
            step();
            get_record(k, 6);
        end
        step();
        chk_done("busy_start");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fuzzy_sweep_sequencer.md
Name: fuzzy_sweep_sequencer

Overview:
Hardware sweep engine that sits directly upstream of Fuzzy_1 and also captures its result. It drives the controller inputs Entrada_01/Entrada_02 over a 2-D grid, clamped to the valid input range, and waits a fixed settle time per point. It then samples saida_defuzzy and FOU_ATIVO and streams each (x, y, result) record out over a valid/ready handshake. This lets the input/output characterisation run on-chip or in a lightweight bench.

Parameters:
STEP, 1, index increment for both axes (1..128)
LAST, 254, last index of each axis, inclusive (≤ 511; index counters are 9 bits)
MIN_IN, 1, lower clamp for driven inputs
MAX_IN, 254, upper clamp for driven inputs
SETTLE, 6, clk_0 cycles the inputs are held before sampling (≥ 2)

Ports:
clk_0  in  1  single clock; all logic on its rising edge
Srst  in  1  reset, synchronous, active-high
start  in  1  begin sweep; honoured only in IDLE or DONE
abort  in  1  stop sweep; return to IDLE next cycle
saida_defuzzy  in  8  crisp output from Fuzzy_1
FOU_ATIVO  in  6  active-FOU flags from Fuzzy_1
Entrada_01  out  8  driven input 1 (outer axis, x)
Entrada_02  out  8  driven input 2 (inner axis, y)
EN_REGRAS  out  1  rule-evaluation enable to Fuzzy_1
out_valid  out  1  record valid
out_ready  in  1  consumer accepts record
out_x  out  8  Entrada_01 value for this record
out_y  out  8  Entrada_02 value for this record
out_data  out  8  sampled saida_defuzzy
out_fou  out  6  sampled FOU_ATIVO
out_last  out  1  record is the final grid point
busy  out  1  high in SETTLE/EMIT
done  out  1  high in DONE

Behaviour:
- Reset (Srst high at a clk_0 edge, from any state): go to IDLE. Entrada_01 = Entrada_02 = MIN_IN. EN_REGRAS = 0. out_valid = 0. out_x/out_y/out_data/out_fou = 0. out_last = 0. busy = 0. done = 0. Indices i = j = 0. Srst has priority over abort, and abort has priority over start.
- Clamp: drive(k) = MIN_IN if k < MIN_IN; MAX_IN if k > MAX_IN; else k[7:0]. Entrada_01 = drive(i), Entrada_02 = drive(j). The inputs are registered and change only on entry to SETTLE.
- States:
  - IDLE: on start, set i = j = 0, load the inputs, set the settle counter to 0, and go to SETTLE.
  - SETTLE: EN_REGRAS = 1. The counter increments each cycle. In the cycle where counter == SETTLE-1, latch saida_defuzzy, FOU_ATIVO, drive(i) and drive(j) into the out_* registers. Set out_valid = 1 and out_last = (i+STEP > LAST) && (j+STEP > LAST), then go to EMIT. out_valid therefore rises exactly SETTLE cycles after the inputs change.
  - EMIT: all out_* are held stable while out_valid && !out_ready. On out_valid && out_ready, deassert out_valid the next cycle, then:
    - if out_last: go to DONE;
    - else if j+STEP ≤ LAST: j += STEP;
    - else: j = 0, i += STEP.
    - In both non-last cases, load the new inputs and go to SETTLE with the counter at 0.
  - DONE: done = 1, EN_REGRAS = 0, the inputs hold their last values. start restarts the sweep exactly as from IDLE.
- Ordering: y is the inner loop (row-major in x). Point count = (floor(LAST/STEP)+1)^2; the default is 255 × 255 = 65025.
- Index arithmetic is 9-bit unsigned. i+STEP is compared before updating, so no wrap occurs; LAST up to 511 is legal.
- abort in any non-IDLE state: next cycle go to IDLE, out_valid = 0, EN_REGRAS = 0, done = 0. A record that was pending is dropped, not completed.
- start while busy is ignored.
- start and abort together: abort wins. start and Srst together: reset wins.
- The consumer may hold out_ready high permanently. Throughput is then 1 record per SETTLE+1 cycles.

Test Plan:
- Reset, then idle for 20 cycles -> Entrada_01 = Entrada_02 = 1, out_valid = 0, busy = 0, done = 0, EN_REGRAS = 0.
- STEP=128, LAST=256, out_ready tied 1, start pulse -> 9 records with (x,y) = (1,1), (1,128), (1,254), (128,1) … (254,254). out_last is set only on the 9th record, then done = 1.
- SETTLE=6; inputs change at cycle T -> out_valid rises at T+6 and out_data equals saida_defuzzy sampled at T+5.
- Backpressure: hold out_ready = 0 for 10 cycles during EMIT -> out_valid, out_x, out_y, out_data and out_fou stay constant, and the inputs do not change. Releasing out_ready advances exactly one point.
- abort asserted on the 4th record of the STEP=128 sweep -> next cycle in IDLE with out_valid = 0 and no further records. A subsequent start restarts at (1,1).
- Srst asserted mid-SETTLE together with start -> all outputs at reset values the next cycle. start pulsed while busy is ignored: the record count is unchanged.
